ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage directly downstream of the decode/execute pipeline register.
- Consumes the latched register specifiers, offset and control bundle, plus operand data and PC+4.
- Computes the ALU or shifter result, selects the destination register, resolves the branch condition and jump.
- Registers the results into the execute/memory boundary, with valid, stall and flush control and a one-cycle redirect pulse to fetch.

Parameters:
- DW, 32, datapath width; only 32 is supported.
- LINK_REG, 31, destination register forced when RegDt0 is 1.

Ports:
- clk  in  1  stage clock; all state updates on the falling edge, matching the neighbouring pipeline registers.
- rst_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  the incoming bundle is a real instruction.
- stall  in  1  hold all outputs this cycle (downstream memory busy).
- flush  in  1  discard the incoming bundle; insert a bubble.
- pc_plus4  in  32  PC+4 of the instruction in execute.
- rs_data  in  32  Rs operand, already forwarded.
- rt_data  in  32  Rt operand, already forwarded.
- Rs_in, Rt_in, Rd_in  in  5 each  register specifiers.
- offset_in  in  32  sign-extended immediate; bits [10:6] hold shamt.
- RegDst_in  in  1  0 selects Rt as destination, 1 selects Rd.
- Shift_amountSrc_in  in  1  0 selects offset_in[10:6], 1 selects rs_data[4:0].
- Jump_in  in  1  unconditional jump.
- ALUShift_Sel_in  in  1  0 selects the ALU result, 1 selects the shifter result.
- RegDt0_in  in  1  force destination to LINK_REG and result to pc_plus4+4.
- ALU_op_in  in  4  ALU operation.
- Shift_op_in  in  2  shift operation.
- ALUSrcB_in  in  3  ALU B-operand select.
- Condition_in  in  3  branch condition.
- valid_out  out  1  registered valid.
- result_out  out  32  registered result.
- store_data_out  out  32  registered rt_data.
- dest_out  out  5  registered destination register.
- redirect_out  out  1  one-cycle pulse: fetch must go to target_out.
- target_out  out  32  registered redirect target.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0. Applies immediately, including mid-stall.
- ALU_op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT (signed), 7 SLTU, 8 LUI (B<<16).
  - 9-15 produce 0.
  - Add and subtract wrap modulo 2^32; no overflow trap.
- ALUSrcB encoding:
  - 0 rt_data.
  - 1 offset_in.
  - 2 zero-extended offset_in[15:0].
  - 3 offset_in<<16.
  - 4-7 constant 0.
- Shift_op encoding: 0 SLL, 1 SRL, 2 SRA, 3 ROTR. The operand is rt_data; the amount is 5 bits, so amount 0 passes rt_data through.
- Condition encoding:
  - 0 never, 1 rs==rt, 2 rs!=rt.
  - 3 rs<=0, 4 rs>0, 5 rs<0, 6 rs>=0 (all signed).
  - 7 never.
- Destination register:
  - RegDt0=1: LINK_REG, and the result is pc_plus4+4.
  - Otherwise: RegDst ? Rd_in : Rt_in.
- Redirect target:
  - Branch: pc_plus4 + (offset_in<<2), wrapping modulo 2^32.
  - Jump: {pc_plus4[31:28], offset_in[25:0], 2'b00}.
  - If both Jump and the condition are true, jump wins.
- Advance rule on each falling edge, in priority order:
  1. flush=1: valid_out←0, redirect_out←0, data outputs hold. Flush overrides stall.
  2. Else stall=1: every output holds, except redirect_out←0 (a redirect is never re-issued while stalled).
  3. Else: valid_out←valid_in; result, store data, dest and target are latched.
- redirect_out←valid_in & (jump | condition true) in the advance case only.
- Latency: exactly one falling edge from inputs to outputs.
- A bundle with valid_in=0 still latches its data, but valid_out=0 and redirect_out=0.

Decomposition:
- Shared package ex_pkg holds:
  - ALU_op, Shift_op, ALUSrcB and Condition encodings as named constants.
  - LINK_REG default.
  - Datapath width.
- One sub-module, ex_alu_shift: a purely combinational ALU, shifter and condition evaluator, reused by later verification models.
- ex_stage owns target and destination selection and the output register.

Test Plan:
- ADD: rs_data=0x7FFFFFFF, rt_data=1, ALU_op=0, ALUSrcB=0, RegDst=1, Rd=9, valid_in=1 → next edge: result_out=0x80000000, dest_out=9, valid_out=1, redirect_out=0.
- SRA from register: Shift_amountSrc=1, rs_data=4, rt_data=0xF0000000, ALUShift_Sel=1, Shift_op=2 → result_out=0xFF000000. Repeat with rs_data=0 → result_out=0xF0000000.
- Branch taken: Condition=1, rs_data=rt_data=5, pc_plus4=0x100, offset_in=0xFFFFFFFF → redirect_out pulses for one cycle, target_out=0xFC. The next instruction has valid_in=0 → redirect_out=0.
- Jump and link: Jump=1, RegDt0=1, pc_plus4=0x40000010, offset_in=0x0000_0040 → target_out=0x40000100, dest_out=31, result_out=0x40000014.
- Stall then flush:
  - Latch ADD result 3.
  - Hold stall=1 for 2 edges with changing inputs → outputs stay at 3.
  - Assert stall=1 and flush=1 together → valid_out=0.
- Asynchronous reset: drop rst_n between edges while valid_out=1 and redirect_out=1 → all outputs 0 immediately. After rst_n rises, the first edge latches normally.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared encodings and defaults for the execute stage and its models.
package ex_pkg;

  localparam int          DW_DEF       = 32;
  localparam logic [4:0]  LINK_REG_DEF = 5'd31;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_LUI  = 4'd8
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_SLL  = 2'd0,
    SH_SRL  = 2'd1,
    SH_SRA  = 2'd2,
    SH_ROTR = 2'd3
  } shift_op_e;

  typedef enum logic [2:0] {
    SRCB_RT    = 3'd0,
    SRCB_OFS   = 3'd1,
    SRCB_ZEXT  = 3'd2,
    SRCB_UPPER = 3'd3
  } alusrcb_e;

  typedef enum logic [2:0] {
    COND_NEVER = 3'd0,
    COND_EQ    = 3'd1,
    COND_NE    = 3'd2,
    COND_LEZ   = 3'd3,
    COND_GTZ   = 3'd4,
    COND_LTZ   = 3'd5,
    COND_GEZ   = 3'd6,
    COND_NEVR7 = 3'd7
  } cond_e;

endpackage

// File: rtl/ex_alu_shift.sv
// Combinational ALU, barrel shifter and branch-condition evaluator.
module ex_alu_shift
  import ex_pkg::*;
(
  input  logic [DW_DEF-1:0] rs_i,
  input  logic [DW_DEF-1:0] rt_i,
  input  logic [DW_DEF-1:0] offset_i,
  input  logic [3:0]        alu_op_i,
  input  logic [1:0]        shift_op_i,
  input  logic [2:0]        alusrcb_i,
  input  logic              shamt_src_i,
  input  logic              alushift_sel_i,
  input  logic [2:0]        cond_i,
  output logic [DW_DEF-1:0] result_o,
  output logic              cond_true_o
);

  logic        [DW_DEF-1:0] opb;
  logic        [DW_DEF-1:0] alu_res;
  logic        [DW_DEF-1:0] sh_res;
  logic        [4:0]        shamt;
  logic signed [DW_DEF-1:0] rs_s;
  logic signed [DW_DEF-1:0] rt_s;
  logic signed [DW_DEF-1:0] opb_s;

  assign rs_s  = rs_i;
  assign rt_s  = rt_i;
  assign opb_s = opb;
  assign shamt = shamt_src_i ? rs_i[4:0] : offset_i[10:6];

  // Select the ALU B operand; unused encodings feed a zero operand.
  always_comb begin
    opb = '0;
    case (alusrcb_i)
      SRCB_RT:    opb = rt_i;
      SRCB_OFS:   opb = offset_i;
      SRCB_ZEXT:  opb = {16'h0000, offset_i[15:0]};
      SRCB_UPPER: opb = {offset_i[15:0], 16'h0000};
      default:    opb = '0;
    endcase
  end

  // ALU; add/sub wrap silently, undefined opcodes yield zero.
  always_comb begin
    alu_res = '0;
    case (alu_op_i)
      ALU_ADD:  alu_res = rs_i + opb;
      ALU_SUB:  alu_res = rs_i - opb;
      ALU_AND:  alu_res = rs_i & opb;
      ALU_OR:   alu_res = rs_i | opb;
      ALU_XOR:  alu_res = rs_i ^ opb;
      ALU_NOR:  alu_res = ~(rs_i | opb);
      ALU_SLT:  alu_res = {{(DW_DEF-1){1'b0}}, (rs_s < opb_s)};
      ALU_SLTU: alu_res = {{(DW_DEF-1){1'b0}}, (rs_i < opb)};
      ALU_LUI:  alu_res = {opb[15:0], 16'h0000};
      default:  alu_res = '0;
    endcase
  end

  // Shifter on rt; rotate uses a doubled word so amount 0 is a pass-through.
  always_comb begin
    sh_res = rt_i;
    case (shift_op_i)
      SH_SLL:  sh_res = rt_i << shamt;
      SH_SRL:  sh_res = rt_i >> shamt;
      SH_SRA:  sh_res = $unsigned(rt_s >>> shamt);
      SH_ROTR: sh_res = DW_DEF'({rt_i, rt_i} >> shamt);
      default: sh_res = rt_i;
    endcase
  end

  // Branch condition; zero comparisons treat rs as signed.
  always_comb begin
    cond_true_o = 1'b0;
    case (cond_i)
      COND_EQ:  cond_true_o = (rs_i == rt_i);
      COND_NE:  cond_true_o = (rs_i != rt_i);
      COND_LEZ: cond_true_o = (rs_s <= 0);
      COND_GTZ: cond_true_o = (rs_s > 0);
      COND_LTZ: cond_true_o = (rs_s < 0);
      COND_GEZ: cond_true_o = (rs_s >= 0);
      default:  cond_true_o = 1'b0;
    endcase
  end

  assign result_o = alushift_sel_i ? sh_res : alu_res;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: computes result, destination and redirect, and registers
// them into the execute/memory boundary on the falling clock edge.
module ex_stage
  import ex_pkg::*;
#(
  parameter int         DW       = DW_DEF,
  parameter logic [4:0] LINK_REG = LINK_REG_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_in,
  input  logic          stall,
  input  logic          flush,
  input  logic [DW-1:0] pc_plus4,
  input  logic [DW-1:0] rs_data,
  input  logic [DW-1:0] rt_data,
  input  logic [4:0]    Rs_in,
  input  logic [4:0]    Rt_in,
  input  logic [4:0]    Rd_in,
  input  logic [DW-1:0] offset_in,
  input  logic          RegDst_in,
  input  logic          Shift_amountSrc_in,
  input  logic          Jump_in,
  input  logic          ALUShift_Sel_in,
  input  logic          RegDt0_in,
  input  logic [3:0]    ALU_op_in,
  input  logic [1:0]    Shift_op_in,
  input  logic [2:0]    ALUSrcB_in,
  input  logic [2:0]    Condition_in,
  output logic          valid_out,
  output logic [DW-1:0] result_out,
  output logic [DW-1:0] store_data_out,
  output logic [4:0]    dest_out,
  output logic          redirect_out,
  output logic [DW-1:0] target_out
);

  logic [DW-1:0] core_res;
  logic          cond_true;
  logic [DW-1:0] exec_res;
  logic [4:0]    exec_dest;
  logic [DW-1:0] exec_tgt;
  logic [DW-1:0] br_tgt;
  logic [DW-1:0] jmp_tgt;

  logic          valid_q,    valid_d;
  logic          redirect_q, redirect_d;
  logic [DW-1:0] result_q,   result_d;
  logic [DW-1:0] store_q,    store_d;
  logic [4:0]    dest_q,     dest_d;
  logic [DW-1:0] target_q,   target_d;

  // Rs specifier travels with the bundle for hazard logic elsewhere; not needed here.
  logic unused_rs;
  assign unused_rs = ^Rs_in;

  ex_alu_shift u_alu_shift (
    .rs_i           (rs_data),
    .rt_i           (rt_data),
    .offset_i       (offset_in),
    .alu_op_i       (ALU_op_in),
    .shift_op_i     (Shift_op_in),
    .alusrcb_i      (ALUSrcB_in),
    .shamt_src_i    (Shift_amountSrc_in),
    .alushift_sel_i (ALUShift_Sel_in),
    .cond_i         (Condition_in),
    .result_o       (core_res),
    .cond_true_o    (cond_true)
  );

  assign br_tgt  = pc_plus4 + {offset_in[DW-3:0], 2'b00};
  assign jmp_tgt = {pc_plus4[DW-1:28], offset_in[25:0], 2'b00};

  // Link instructions override both the destination and the written value.
  always_comb begin
    exec_res  = core_res;
    exec_dest = RegDst_in ? Rd_in : Rt_in;
    exec_tgt  = Jump_in ? jmp_tgt : br_tgt;
    if (RegDt0_in) begin
      exec_res  = pc_plus4 + 32'd4;
      exec_dest = LINK_REG;
    end
  end

  // Advance priority: flush beats stall beats normal latch; redirect only fires on advance.
  always_comb begin
    valid_d    = valid_q;
    redirect_d = 1'b0;
    result_d   = result_q;
    store_d    = store_q;
    dest_d     = dest_q;
    target_d   = target_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d    = valid_in;
      redirect_d = valid_in & (Jump_in | cond_true);
      result_d   = exec_res;
      store_d    = rt_data;
      dest_d     = exec_dest;
      target_d   = exec_tgt;
    end
  end

  // Execute/memory boundary register, clocked on the falling edge like its neighbours.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      redirect_q <= 1'b0;
      result_q   <= '0;
      store_q    <= '0;
      dest_q     <= '0;
      target_q   <= '0;
    end else begin
      valid_q    <= valid_d;
      redirect_q <= redirect_d;
      result_q   <= result_d;
      store_q    <= store_d;
      dest_q     <= dest_d;
      target_q   <= target_d;
    end
  end

  assign valid_out      = valid_q;
  assign redirect_out   = redirect_q;
  assign result_out     = result_q;
  assign store_data_out = store_q;
  assign dest_out       = dest_q;
  assign target_out     = target_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: behavioural reference model plus directed literal checks.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in, stall, flush;
  logic [31:0] pc_plus4, rs_data, rt_data, offset_in;
  logic [4:0]  Rs_in, Rt_in, Rd_in;
  logic        RegDst_in, Shift_amountSrc_in, Jump_in, ALUShift_Sel_in, RegDt0_in;
  logic [3:0]  ALU_op_in;
  logic [1:0]  Shift_op_in;
  logic [2:0]  ALUSrcB_in, Condition_in;
  logic        valid_out, redirect_out;
  logic [31:0] result_out, store_data_out, target_out;
  logic [4:0]  dest_out;

  int errs = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic        e_valid = 0, e_redir = 0;
  logic [31:0] e_result = 0, e_store = 0, e_target = 0;
  logic [4:0]  e_dest = 0;
  logic        n_valid, n_redir;
  logic [31:0] n_result, n_store, n_target;
  logic [4:0]  n_dest;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .stall(stall), .flush(flush),
    .pc_plus4(pc_plus4), .rs_data(rs_data), .rt_data(rt_data),
    .Rs_in(Rs_in), .Rt_in(Rt_in), .Rd_in(Rd_in), .offset_in(offset_in),
    .RegDst_in(RegDst_in), .Shift_amountSrc_in(Shift_amountSrc_in), .Jump_in(Jump_in),
    .ALUShift_Sel_in(ALUShift_Sel_in), .RegDt0_in(RegDt0_in), .ALU_op_in(ALU_op_in),
    .Shift_op_in(Shift_op_in), .ALUSrcB_in(ALUSrcB_in), .Condition_in(Condition_in),
    .valid_out(valid_out), .result_out(result_out), .store_data_out(store_data_out),
    .dest_out(dest_out), .redirect_out(redirect_out), .target_out(target_out)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: what the stage must compute from the current inputs.
  function automatic logic [31:0] ref_result();
    logic [31:0] b, r;
    int amt;
    if (RegDt0_in) return pc_plus4 + 4;
    if (ALUShift_Sel_in) begin
      amt = Shift_amountSrc_in ? int'(rs_data % 32) : int'((offset_in / 64) % 32);
      r = rt_data;
      case (Shift_op_in)
        2'd0: r = rt_data << amt;
        2'd1: r = rt_data >> amt;
        2'd2: r = $unsigned($signed(rt_data) >>> amt);
        default: for (int i = 0; i < amt; i++) r = {r[0], r[31:1]};
      endcase
      return r;
    end
    case (ALUSrcB_in)
      3'd0: b = rt_data;
      3'd1: b = offset_in;
      3'd2: b = offset_in % 65536;
      3'd3: b = offset_in * 65536;
      default: b = 0;
    endcase
    case (ALU_op_in)
      4'd0: return rs_data + b;
      4'd1: return rs_data - b;
      4'd2: return rs_data & b;
      4'd3: return rs_data | b;
      4'd4: return rs_data ^ b;
      4'd5: return ~(rs_data | b);
      4'd6: return ($signed(rs_data) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7: return (rs_data < b) ? 32'd1 : 32'd0;
      4'd8: return b * 65536;
      default: return 0;
    endcase
  endfunction

  function automatic bit ref_cond();
    int signed s;
    s = $signed(rs_data);
    case (Condition_in)
      3'd1: return rs_data == rt_data;
      3'd2: return rs_data != rt_data;
      3'd3: return s <= 0;
      3'd4: return s > 0;
      3'd5: return s < 0;
      3'd6: return s >= 0;
      default: return 0;
    endcase
  endfunction

  task automatic model_next();
    n_valid = e_valid; n_redir = 0; n_result = e_result;
    n_store = e_store; n_dest = e_dest; n_target = e_target;
    if (!rst_n) begin
      n_valid = 0; n_result = 0; n_store = 0; n_dest = 0; n_target = 0;
    end else if (flush) begin
      n_valid = 0;
    end else if (!stall) begin
      n_valid  = valid_in;
      n_redir  = valid_in && (Jump_in || ref_cond());
      n_result = ref_result();
      n_store  = rt_data;
      n_dest   = RegDt0_in ? 5'd31 : (RegDst_in ? Rd_in : Rt_in);
      n_target = Jump_in ? {pc_plus4[31:28], offset_in[25:0], 2'b00}
                         : pc_plus4 + offset_in * 4;
    end
  endtask

  // One stage step: model advances at the falling edge, outputs compared at the rising edge.
  task automatic tick();
    model_next();
    @(negedge clk); #1;
    e_valid = n_valid; e_redir = n_redir; e_result = n_result;
    e_store = n_store; e_dest = n_dest; e_target = n_target;
    @(posedge clk); #1;
  endtask

  task automatic clr_in();
    valid_in = 0; stall = 0; flush = 0; pc_plus4 = 0; rs_data = 0; rt_data = 0;
    offset_in = 0; Rs_in = 0; Rt_in = 0; Rd_in = 0; RegDst_in = 0;
    Shift_amountSrc_in = 0; Jump_in = 0; ALUShift_Sel_in = 0; RegDt0_in = 0;
    ALU_op_in = 0; Shift_op_in = 0; ALUSrcB_in = 0; Condition_in = 0;
  endtask

  // Compare every output against the model on each rising edge.
  always @(posedge clk) begin
    if (chk_en) begin
      chk("valid_out", {31'b0, valid_out}, {31'b0, e_valid});
      chk("redirect_out", {31'b0, redirect_out}, {31'b0, e_redir});
      chk("result_out", result_out, e_result);
      chk("store_data_out", store_data_out, e_store);
      chk("dest_out", {27'b0, dest_out}, {27'b0, e_dest});
      chk("target_out", target_out, e_target);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_in();
    rst_n = 0;
    @(negedge clk); #1;
    chk_en = 1;
    @(posedge clk); #1;
    rst_n = 1;

    // ADD wrap into sign bit
    clr_in(); valid_in = 1; rs_data = 32'h7FFFFFFF; rt_data = 1; RegDst_in = 1; Rd_in = 9; Rt_in = 4;
    tick();
    chk("add_result", result_out, 32'h80000000);
    chk("add_dest", {27'b0, dest_out}, 32'd9);
    chk("add_valid", {31'b0, valid_out}, 32'd1);
    chk("add_redirect", {31'b0, redirect_out}, 32'd0);
    chk("model_add", e_result, 32'h80000000);

    // SRA by register amount, then amount zero
    clr_in(); valid_in = 1; Shift_amountSrc_in = 1; rs_data = 4; rt_data = 32'hF0000000;
    ALUShift_Sel_in = 1; Shift_op_in = 2;
    tick();
    chk("sra4", result_out, 32'hFF000000);
    rs_data = 0;
    tick();
    chk("sra0", result_out, 32'hF0000000);

    // Branch taken backward, then a bubble must not redirect
    clr_in(); valid_in = 1; Condition_in = 1; rs_data = 5; rt_data = 5;
    pc_plus4 = 32'h100; offset_in = 32'hFFFFFFFF;
    tick();
    chk("br_redirect", {31'b0, redirect_out}, 32'd1);
    chk("br_target", target_out, 32'h000000FC);
    chk("model_br_target", e_target, 32'h000000FC);
    valid_in = 0;
    tick();
    chk("br_bubble_redirect", {31'b0, redirect_out}, 32'd0);
    chk("br_bubble_valid", {31'b0, valid_out}, 32'd0);

    // Stall holds, flush over stall kills valid
    clr_in(); valid_in = 1; rs_data = 1; rt_data = 2;
    tick();
    chk("st_add", result_out, 32'd3);
    stall = 1; rs_data = 100; rt_data = 7;
    tick();
    chk("st_hold1", result_out, 32'd3);
    rs_data = 200; Rt_in = 17;
    tick();
    chk("st_hold2", result_out, 32'd3);
    chk("st_hold_valid", {31'b0, valid_out}, 32'd1);
    flush = 1;
    tick();
    chk("fl_valid", {31'b0, valid_out}, 32'd0);
    chk("fl_result_hold", result_out, 32'd3);

    // Jump and link, then asynchronous reset between edges
    clr_in(); valid_in = 1; Jump_in = 1; RegDt0_in = 1; pc_plus4 = 32'h40000010; offset_in = 32'h40;
    tick();
    chk("jal_target", target_out, 32'h40000100);
    chk("jal_dest", {27'b0, dest_out}, 32'd31);
    chk("jal_result", result_out, 32'h40000014);
    chk("jal_redirect", {31'b0, redirect_out}, 32'd1);
    stall = 1;
    rst_n = 0;
    e_valid = 0; e_redir = 0; e_result = 0; e_store = 0; e_dest = 0; e_target = 0;
    #1;
    chk("rst_valid", {31'b0, valid_out}, 32'd0);
    chk("rst_redirect", {31'b0, redirect_out}, 32'd0);
    chk("rst_result", result_out, 32'd0);
    chk("rst_target", target_out, 32'd0);
    chk("rst_dest", {27'b0, dest_out}, 32'd0);
    chk("rst_store", store_data_out, 32'd0);
    #1 rst_n = 1;
    clr_in(); valid_in = 1; rs_data = 10; rt_data = 20; Rt_in = 6;
    tick();
    chk("post_rst_result", result_out, 32'd30);
    chk("post_rst_dest", {27'b0, dest_out}, 32'd6);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      valid_in = ($urandom_range(3) != 0);
      stall = ($urandom_range(3) == 0);
      flush = ($urandom_range(7) == 0);
      pc_plus4 = $urandom; rs_data = $urandom; offset_in = $urandom;
      rt_data = ($urandom_range(3) == 0) ? rs_data : $urandom;
      if ($urandom_range(7) == 0) rs_data = 0;
      Rs_in = 5'($urandom); Rt_in = 5'($urandom); Rd_in = 5'($urandom);
      RegDst_in = 1'($urandom); Shift_amountSrc_in = 1'($urandom);
      Jump_in = ($urandom_range(5) == 0); ALUShift_Sel_in = 1'($urandom);
      RegDt0_in = ($urandom_range(7) == 0);
      ALU_op_in = 4'($urandom); Shift_op_in = 2'($urandom);
      ALUSrcB_in = 3'($urandom); Condition_in = 3'($urandom);
      tick();
    end

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
